// File: rtl/bcd2_seg7_scan.sv
// Two-digit multiplexed 7-segment driver: captures a TEN/ONE BCD pair and scans it with dead time and blinking.
// Optional build macro LZ_BLANK_EN blanks the tens digit when it is zero.
module bcd2_seg7_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter int DEAD_CYC     = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] TEN,
  input  logic [3:0] ONE,
  input  logic       blink,
  output logic [6:0] SEG,
  output logic [1:0] AN,
  output logic       err
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_CYC);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_ONES  = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;

  typedef enum logic {
    SLOT_ONES = 1'b0,
    SLOT_TENS = 1'b1
  } slot_e;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  logic [3:0]       ten_q, one_q, ten_d, one_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  slot_e            sel, sel_d;
  logic [BLK_W-1:0] blink_cnt, blink_cnt_d;
  logic             phase, phase_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;
  logic             slot_end, frame_end, blank;
  logic [3:0]       digit;

  always_comb begin
    ten_d       = ten_q;
    one_d       = one_q;
    err_d       = err_q;
    cnt_d       = cnt + 1'b1;
    sel_d       = sel;
    blink_cnt_d = blink_cnt;
    phase_d     = phase;
    slot_end    = (cnt == CNT_LAST);
    frame_end   = slot_end && (sel == SLOT_TENS);

    // load has no back-pressure: every edge with load=1 captures TEN/ONE.
    if (load) begin
      ten_d = TEN;
      one_d = ONE;
      err_d = (TEN > 4'd9) | (ONE > 4'd9);
    end

    if (slot_end) begin
      cnt_d = '0;
      sel_d = (sel == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
    end

    if (!blink) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == BLK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase;
      end else begin
        blink_cnt_d = blink_cnt + 1'b1;
      end
    end

    // Outputs are computed from pre-edge state so AN and SEG switch together.
    digit = (sel == SLOT_TENS) ? ten_q : one_q;
    blank = (cnt < DEAD_LIM) | (blink & phase);
`ifdef LZ_BLANK_EN
    blank = blank | ((sel == SLOT_TENS) && (ten_q == 4'd0));
`endif
    an_d  = blank ? AN_OFF : ((sel == SLOT_TENS) ? AN_TENS : AN_ONES);
    seg_d = blank ? SEG_OFF : decode(digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ten_q     <= 4'd0;
      one_q     <= 4'd0;
      err_q     <= 1'b0;
      cnt       <= '0;
      sel       <= SLOT_ONES;
      blink_cnt <= '0;
      phase     <= 1'b0;
      seg_q     <= SEG_OFF;
      an_q      <= AN_OFF;
    end else begin
      ten_q     <= ten_d;
      one_q     <= one_d;
      err_q     <= err_d;
      cnt       <= cnt_d;
      sel       <= sel_d;
      blink_cnt <= blink_cnt_d;
      phase     <= phase_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign SEG = seg_q;
  assign AN  = an_q;
  assign err = err_q;

endmodule
